// File: rtl/dogbattle_pkg.sv
// Shared types and constants for the dogbattle UART transmitter.
// Holds the tx FSM state enum, default bit period and counter sizing.
package dogbattle_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Width of a down-counter that must hold CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/dogbattle_uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// Ports: tx_data/tx_valid from producer, tx_ready back from the transmitter.
interface dogbattle_uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/dogbattle_baud_gen.sv
// Bit-period down-counter for the UART transmitter.
// Ports: clk, rst_n, load_i (reload to CLKS_PER_BIT-1), tick_o (count is zero).
module dogbattle_baud_gen
    import dogbattle_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic tick_o
);

    localparam int            CW     = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reloading on every boundary keeps each bit exactly
    // CLKS_PER_BIT cycles, so no error accumulates over a frame.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/dogbattle_uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, 1-2 stops.
// Ports: clk, rst_n, tx_if (slave handshake), tx (serial line), busy.
module dogbattle_uart_tx
    import dogbattle_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dogbattle_uart_tx_if.slave        tx_if,
    output logic                      tx,
    output logic                      busy
);

    localparam logic PAR_ON    = (PARITY_EN != 0);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    tx_state_e  state_q;
    logic       tx_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic [2:0] bit_q;
    logic       stop_q;

    logic ready;
    logic accept;
    logic tick;
    logic load;

    assign ready  = (state_q == ST_IDLE);
    assign accept = ready & tx_if.tx_valid;
    // Reload at acceptance and at every bit boundary inside a frame.
    assign load   = accept | (~ready & tick);

    dogbattle_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(load),
        .tick_o(tick)
    );

    assign tx_if.tx_ready = ready;
    assign busy           = ~ready;
    assign tx             = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        shift_q <= tx_if.tx_data;
                        par_q   <= ^tx_if.tx_data;
                        bit_q   <= '0;
                        stop_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end
                ST_DATA: begin
                    // bit_q indexes the data bit currently on the line.
                    if (tick) begin
                        if (bit_q == 3'd7) begin
                            if (PAR_ON) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_q == STOP_LAST) begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dogbattle_uart_tx.sv
// Directed bench for dogbattle_uart_tx at CLKS_PER_BIT=4.
// Runs a no-parity and an even-parity instance side by side.
module tb_dogbattle_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dogbattle_uart_tx_if if0();
    dogbattle_uart_tx_if if1();

    logic tx0, busy0, tx1, busy1;

    dogbattle_uart_tx #(
        .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_if(if0), .tx(tx0), .busy(busy0)
    );

    dogbattle_uart_tx #(
        .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_if(if1), .tx(tx1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    // Frames are written stop..start so index 0 is the start bit.
    typedef struct {
        logic [7:0]  data;
        logic [9:0]  fr0;
        logic [10:0] fr1;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int k,
                       input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, k, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if0.tx_valid = v;
        if0.tx_data  = d;
        if1.tx_valid = v;
        if1.tx_data  = d;
    endtask

    task automatic chk_both(input string tag, input int k,
                            input logic e0, input logic r0,
                            input logic e1, input logic r1);
        chk({tag, ".tx0"},    k, tx0,           e0);
        chk({tag, ".rdy0"},   k, if0.tx_ready,  r0);
        chk({tag, ".busy0"},  k, busy0,         ~r0);
        chk({tag, ".tx1"},    k, tx1,           e1);
        chk({tag, ".rdy1"},   k, if1.tx_ready,  r1);
        chk({tag, ".busy1"},  k, busy1,         ~r1);
    endtask

    // Starts on the cycle after acceptance; pulses a stray byte mid-frame.
    task automatic watch_frame(input vec_t v);
        logic e0, r0, e1, r1;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            e0 = (k < 40) ? v.fr0[k / CPB] : 1'b1;
            r0 = (k >= 40);
            e1 = (k < 44) ? v.fr1[k / CPB] : 1'b1;
            r1 = (k >= 44);
            chk_both("frame", k, e0, r0, e1, r1);
            if (k == 13) drive(1'b1, 8'h00);
            else         drive(1'b0, ~v.data);
        end
    endtask

    initial begin
        logic [9:0] fa, fb;
        logic       e, r;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0};
        vecs[1] = '{8'h01, 10'b1_00000001_0, 11'b1_1_00000001_0};
        vecs[2] = '{8'h3C, 10'b1_00111100_0, 11'b1_0_00111100_0};
        vecs[3] = '{8'h80, 10'b1_10000000_0, 11'b1_1_10000000_0};
        vecs[4] = '{8'hFF, 10'b1_11111111_0, 11'b1_0_11111111_0};

        rst_n = 1'b0;
        drive(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk_both("in_reset", 0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_both("idle", i, 1'b1, 1'b1, 1'b1, 1'b1);
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].data);
            @(posedge clk);
            #1 drive(1'b0, ~vecs[i].data);
            watch_frame(vecs[i]);
        end

        // Back-to-back on the no-parity instance, valid held high.
        fa = 10'b1_00000000_0;
        fb = 10'b1_11111111_0;
        @(negedge clk);
        drive(1'b1, 8'h00);
        @(posedge clk);
        #1 drive(1'b1, 8'hFF);
        for (int k = 0; k < 89; k++) begin
            @(negedge clk);
            if (k < 40) begin
                e = fa[k / CPB]; r = 1'b0;
            end else if (k == 40) begin
                e = 1'b1; r = 1'b1;
            end else if (k < 81) begin
                e = fb[(k - 41) / CPB]; r = 1'b0;
            end else begin
                e = 1'b1; r = 1'b1;
            end
            chk("b2b.tx0",   k, tx0,          e);
            chk("b2b.rdy0",  k, if0.tx_ready, r);
            chk("b2b.busy0", k, busy0,        ~r);
            if (k == 41) drive(1'b0, 8'hFF);
        end

        // Reset during data bit 3 (cycles 16..19) of 0xA5.
        @(negedge clk);
        drive(1'b1, 8'hA5);
        @(posedge clk);
        #1 drive(1'b0, 8'h5A);
        repeat (18) @(negedge clk);
        chk("pre_rst.tx0",  17, tx0,   1'b0);
        chk("pre_rst.bsy0", 17, busy0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_both("async_rst", 17, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk_both("held_rst", 0, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, vecs[2].data);
        @(posedge clk);
        #1 drive(1'b0, ~vecs[2].data);
        watch_frame(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
